// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial logic/arithmetic unit.
// SERIAL_ALU_SUB_EN makes op 8 (SUB) a legal operation.
package serial_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NAND = 4'd3,
    OP_NOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NOT  = 4'd6,
    OP_ADD  = 4'd7,
    OP_SUB  = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_legal_op(input op_e op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NAND,
      OP_NOR, OP_XNOR, OP_NOT, OP_ADD: legal = 1'b1;
`ifdef SERIAL_ALU_SUB_EN
      OP_SUB:                          legal = 1'b1;
`endif
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/serial_alu_bit_cell.sv
// Combinational one-bit op unit; owns the B inversion for SUB.
// SERIAL_ALU_SUB_EN enables the SUB path.
module serial_alu_bit_cell
  import serial_alu_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  logic cin,
  input  op_e  op,
  output logic r_bit,
  output logic cout
);

  logic b_eff;

  always_comb begin
    b_eff = b_bit;
`ifdef SERIAL_ALU_SUB_EN
    if (op == OP_SUB) b_eff = ~b_bit;
`endif
  end

  always_comb begin
    r_bit = 1'b0;
    cout  = 1'b0;
    case (op)
      OP_AND:  r_bit = a_bit & b_bit;
      OP_OR:   r_bit = a_bit | b_bit;
      OP_XOR:  r_bit = a_bit ^ b_bit;
      OP_NAND: r_bit = ~(a_bit & b_bit);
      OP_NOR:  r_bit = ~(a_bit | b_bit);
      OP_XNOR: r_bit = ~(a_bit ^ b_bit);
      OP_NOT:  r_bit = ~a_bit;
      OP_ADD: begin
        r_bit = a_bit ^ b_eff ^ cin;
        cout  = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);
      end
`ifdef SERIAL_ALU_SUB_EN
      OP_SUB: begin
        r_bit = a_bit ^ b_eff ^ cin;
        cout  = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_logic_alu.sv
// Bit-serial WIDTH-bit logic/ADD unit, one bit per clock LSB first, start/busy/done handshake.
// Define SERIAL_ALU_SUB_EN to add SUB (op 8); otherwise op 8 takes the illegal-op path.
module serial_logic_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q;
  op_e              op_q;
  logic             cy_q;
  logic             busy_q, done_q, carry_q, zero_q, err_q;
  logic [WIDTH-1:0] result_q;

  logic             r_bit, cout;
  logic             is_arith;
  logic             cy_d;
  logic [WIDTH-1:0] res_d;
  op_e              op_in;
  logic             cy_preset;

  serial_alu_bit_cell u_cell (
    .a_bit (a_sr_q[0]),
    .b_bit (b_sr_q[0]),
    .cin   (cy_q),
    .op    (op_q),
    .r_bit (r_bit),
    .cout  (cout)
  );

  always_comb begin
    op_in     = op_e'(op);
    is_arith  = (op_q == OP_ADD);
    cy_preset = 1'b0;
`ifdef SERIAL_ALU_SUB_EN
    is_arith  = is_arith || (op_q == OP_SUB);
    cy_preset = (op_in == OP_SUB);
`endif
    cy_d  = is_arith ? cout : cy_q;
    // New bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
    res_d = {r_bit, res_sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      op_q     <= OP_AND;
      cy_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (start) begin
            if (is_legal_op(op_in)) begin
              a_sr_q   <= a;
              b_sr_q   <= b;
              op_q     <= op_in;
              cy_q     <= cy_preset;
              cnt_q    <= '0;
              res_sr_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_SHIFT;
            end else begin
              result_q <= '0;
              carry_q  <= 1'b0;
              zero_q   <= 1'b1;
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_d;
          cy_q     <= cy_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            carry_q  <= cy_d & is_arith;
            zero_q   <= (res_d == '0);
            err_q    <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_serial_logic_alu.sv
// Scoreboard bench for serial_logic_alu (WIDTH=8); honours SERIAL_ALU_SUB_EN.
module tb_serial_logic_alu;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cy;
    logic         z;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry, zero, err;
  logic [W-1:0] result;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_logic_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .err    (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: e.res = x ^ y;
      4'd3: e.res = ~(x & y);
      4'd4: e.res = ~(x | y);
      4'd5: e.res = ~(x ^ y);
      4'd6: e.res = ~x;
      4'd7: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.cy  = s[W];
      end
`ifdef SERIAL_ALU_SUB_EN
      4'd8: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.res = s[W-1:0];
        e.cy  = s[W];
      end
`endif
      default: e.e = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Completion monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("carry",  64'(carry),  64'(e.cy));
        check("zero",   64'(zero),   64'(e.z));
        check("err",    64'(err),    64'(e.e));
      end
    end
  end

  // Called at #1 after an edge; returns in the done cycle so a follow-up call is back-to-back.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int glitch);
    exp_t e;
    int   lat;
    int   busy_n;
    e = model(o, xa, xb);
    op = o; a = xa; b = xb; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_n = 0;
    for (int k = 0; k < int'(W) + 4; k++) begin
      if (k == glitch) begin
        start = 1'b1; op = 4'd1; a = ~xa; b = ~xb;
      end else if (k == glitch + 1) begin
        start = 1'b0;
      end
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("latency",     64'(lat),    e.e ? 64'(0) : 64'(W));
    check("busy_cycles", 64'(busy_n), e.e ? 64'(0) : 64'(W));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_carry",  64'(carry),  64'(0));
    check("rst_zero",   64'(zero),   64'(0));
    check("rst_err",    64'(err),    64'(0));
    rst = 1'b0;
    idle_cycle();
    check("idle_busy", 64'(busy), 64'(0));

    run_op(4'd2, 8'hF0, 8'h3C, -10);
    idle_cycle();

    // Reset three cycles into SHIFT must abort the op silently.
    op = 4'd7; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) idle_cycle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy",   64'(busy),   64'(0));
    check("abort_done",   64'(done),   64'(0));
    check("abort_result", 64'(result), 64'(0));
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen++;
      idle_cycle();
    end
    check("abort_no_done", 64'(seen), 64'(0));

    run_op(4'd7, 8'hFF, 8'h01, -10);
    idle_cycle();
    run_op(4'd6, 8'hA5, 8'hFF, -10);
    run_op(4'd3, 8'hFF, 8'hFF, -10);
    idle_cycle();
    run_op(4'hF, 8'h55, 8'hAA, -10);
    idle_cycle();
    run_op(4'd8, 8'h05, 8'h07, -10);
    idle_cycle();
    run_op(4'd0, 8'h0F, 8'hFF, -10);
    idle_cycle();
    run_op(4'd2, 8'hF0, 8'h3C, 3);
    idle_cycle();
    run_op(4'd7, 8'h80, 8'h7F, -10);
    run_op(4'd4, 8'h00, 8'h00, -10);
    idle_cycle();
    run_op(4'd5, 8'h3C, 8'h3C, -10);
    idle_cycle();

    for (int i = 0; i < 12; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), -10);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    repeat (3) idle_cycle();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
